sine_dds: RTL and testbench

Tick-paced direct digital synthesis (DDS) sine generator for the SineWave project. It sits directly downstream of the modulus-MAX tick counter and consumes its single-cycle `tick` as a sample-rate enable. On each tick, a phase accumulator advances by a frequency tuning word. A three-stage pipeline folds the phase into a quarter-wave ROM and emits one signed sine sample per tick. Its output feeds the DAC/serializer stage.

---
 rtl/sine_dds_if.sv | 23 ++
 rtl/sine_dds.sv | 135 +++++++++++++
 tb/tb_sine_dds.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_dds_if.sv
// Sample-path bundle between the tick source / DAC side and the sine DDS core.
// The master drives tick, clear and tuning word; the slave returns samples.
interface sine_dds_if #(
  parameter int PHASE_WIDTH = 32,
  parameter int DATA_WIDTH  = 12
);
  logic                   tick;
  logic                   sync_clr;
  logic [PHASE_WIDTH-1:0] ftw;
  logic [DATA_WIDTH-1:0]  sample;
  logic                   sample_valid;
  logic                   cycle_start;

  modport master (
    output tick, sync_clr, ftw,
    input  sample, sample_valid, cycle_start
  );

  modport slave (
    input  tick, sync_clr, ftw,
    output sample, sample_valid, cycle_start
  );
endinterface

// File: rtl/sine_dds.sv
// Tick-paced DDS sine generator: phase accumulator, quarter-wave fold,
// registered quarter-wave ROM and signed output stage (three registers deep).
module sine_dds #(
  parameter int PHASE_WIDTH = 32,
  parameter int LUT_ADDR    = 8,
  parameter int DATA_WIDTH  = 12
) (
  input  logic      clk,
  input  logic      rst_n,
  sine_dds_if.slave dds
);

  localparam int                ROM_DEPTH = 1 << LUT_ADDR;
  localparam int                PH_BITS   = LUT_ADDR + 2;
  localparam logic [LUT_ADDR-1:0] ADDR_MAX = '1;
  localparam longint            PI_Q30    = 64'd3373259426;

  // Q[i] = round(amp * sin(pi/2 * (i+0.5)/2^LUT_ADDR)), evaluated with a
  // Q30 fixed-point Taylor series so the table folds to constants.
  function automatic logic [DATA_WIDTH-1:0] quarter_sine(input int idx);
    longint x;
    longint x2;
    longint term;
    longint sum_q30;
    longint amp;
    x       = (PI_Q30 * longint'(2 * idx + 1)) >>> (LUT_ADDR + 2);
    x2      = (x * x) >>> 30;
    term    = x;
    sum_q30 = x;
    for (int n = 1; n <= 8; n++) begin
      term    = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      sum_q30 = sum_q30 + term;
    end
    amp = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;
    return DATA_WIDTH'((amp * sum_q30 + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [DATA_WIDTH-1:0] rom [ROM_DEPTH];

  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] Q_VAL = quarter_sine(gi);
    assign rom[gi] = Q_VAL;
  end

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic                   acc_wrap_q, acc_wrap_d;
  logic [PH_BITS-1:0]     ph1_q, ph1_d;
  logic                   wrap1_q, wrap1_d;
  logic                   v1_q, v1_d;
  logic [DATA_WIDTH-1:0]  rom_q, rom_d;
  logic                   neg2_q, neg2_d;
  logic                   wrap2_q, wrap2_d;
  logic                   v2_q, v2_d;
  logic [DATA_WIDTH-1:0]  sample_q, sample_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   cycle_start_q, cycle_start_d;

  logic [PHASE_WIDTH:0]   sum;
  logic [1:0]             quad;
  logic [LUT_ADDR-1:0]    k;
  logic [LUT_ADDR-1:0]    addr;

  always_comb begin
    sum  = {1'b0, acc_q} + {1'b0, dds.ftw};
    quad = ph1_q[PH_BITS-1 -: 2];
    k    = ph1_q[LUT_ADDR-1:0];
    addr = quad[0] ? (ADDR_MAX - k) : k;

    acc_d      = acc_q;
    acc_wrap_d = acc_wrap_q;
    ph1_d      = ph1_q;
    wrap1_d    = wrap1_q;
    v1_d       = 1'b0;

    // acc_wrap remembers whether the add that produced acc crossed zero, so the
    // sample taken from that new phase is the one flagged as a cycle start.
    if (dds.sync_clr) begin
      acc_d      = '0;
      acc_wrap_d = 1'b0;
    end else if (dds.tick) begin
      ph1_d      = acc_q[PHASE_WIDTH-1 -: PH_BITS];
      wrap1_d    = acc_wrap_q;
      acc_d      = sum[PHASE_WIDTH-1:0];
      acc_wrap_d = sum[PHASE_WIDTH];
      v1_d       = 1'b1;
    end

    rom_d   = rom[addr];
    neg2_d  = quad[1];
    wrap2_d = wrap1_q;
    v2_d    = v1_q & ~dds.sync_clr;

    sample_d       = sample_q;
    sample_valid_d = v2_q & ~dds.sync_clr;
    cycle_start_d  = v2_q & wrap2_q & ~dds.sync_clr;
    if (v2_q && !dds.sync_clr) begin
      sample_d = neg2_q ? -rom_q : rom_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      acc_wrap_q     <= 1'b0;
      ph1_q          <= '0;
      wrap1_q        <= 1'b0;
      v1_q           <= 1'b0;
      rom_q          <= '0;
      neg2_q         <= 1'b0;
      wrap2_q        <= 1'b0;
      v2_q           <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      cycle_start_q  <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      acc_wrap_q     <= acc_wrap_d;
      ph1_q          <= ph1_d;
      wrap1_q        <= wrap1_d;
      v1_q           <= v1_d;
      rom_q          <= rom_d;
      neg2_q         <= neg2_d;
      wrap2_q        <= wrap2_d;
      v2_q           <= v2_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      cycle_start_q  <= cycle_start_d;
    end
  end

  assign dds.sample       = sample_q;
  assign dds.sample_valid = sample_valid_q;
  assign dds.cycle_start  = cycle_start_q;

endmodule

// File: tb/tb_sine_dds.sv
// Bench for sine_dds: a scoreboard fed by an ideal sine model (accumulated
// phase in turns, real-valued sine) plus a table of short single-run vectors.
module tb_sine_dds;

  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int sample;
    bit cs;
  } exp_t;

  typedef struct {
    logic [31:0] ftw;
    int          nticks;
    int          exp_last;
    int          exp_cs;
  } vec_t;

  logic clk;
  logic rst_n;

  sine_dds_if #(.PHASE_WIDTH(32), .DATA_WIDTH(12)) dds ();

  sine_dds #(
    .PHASE_WIDTH(32),
    .LUT_ADDR   (8),
    .DATA_WIDTH (12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dds  (dds.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  exp_t   exp_q[$];
  longint model_total = 0;
  longint last_turns = 0;
  int     model_last = 0;
  int     cs_count = 0;
  int     max_s = 0;
  int     min_s = 0;
  int     run_len = 0;
  int     max_run = 0;
  int     last_valid_sample = 0;

  // Ideal sample for a phase: 1024 points per turn, sampled at half-point offsets.
  function automatic int ref_sample(input logic [31:0] phase);
    real r;
    int  n;
    n = int'(phase[31:22]);
    r = 2047.0 * $sin(2.0 * PI * (real'(n) + 0.5) / 1024.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_total = 0;
    last_turns  = 0;
  endtask

  // Drives one cycle of inputs at the falling edge and records what the
  // ideal generator should emit for it.
  task automatic applyStimulus(input bit t, input bit c, input logic [31:0] f);
    longint turns;
    exp_t   e;
    @(negedge clk);
    dds.tick     = t;
    dds.sync_clr = c;
    dds.ftw      = f;
    if (c) begin
      model_clear();
    end else if (t) begin
      turns       = model_total >>> 32;
      e.sample    = ref_sample(model_total[31:0]);
      e.cs        = (turns > last_turns);
      last_turns  = turns;
      model_total = model_total + {32'b0, f};
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #3;
      n++;
    end
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  task automatic clear_stats();
    cs_count = 0;
    max_s    = 0;
    min_s    = 0;
    max_run  = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    int   s;
    #2;
    s = int'($signed(dds.sample));
    if (!rst_n) begin
      checkOutput("rst_sample", s, 0);
      checkOutput("rst_valid", int'(dds.sample_valid), 0);
      checkOutput("rst_cycle_start", int'(dds.cycle_start), 0);
      run_len = 0;
    end else if (dds.sample_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sample", s, e.sample);
        checkOutput("cycle_start", int'(dds.cycle_start), int'(e.cs));
        model_last = e.sample;
      end
      last_valid_sample = s;
      if (dds.cycle_start) cs_count++;
      if (s > max_s) max_s = s;
      if (s < min_s) min_s = s;
    end else begin
      run_len = 0;
      checkOutput("sample_hold", s, model_last);
      checkOutput("cycle_start_idle", int'(dds.cycle_start), 0);
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[6];
    int          cycles;
    logic [31:0] f;
    bit          t;
    bit          c;

    vecs[0].ftw = 32'h0040_0000; vecs[0].nticks = 5;
    vecs[1].ftw = 32'h0100_0000; vecs[1].nticks = 17;
    vecs[2].ftw = 32'h4000_0000; vecs[2].nticks = 3;
    vecs[3].ftw = 32'h8000_0000; vecs[3].nticks = 4;
    vecs[4].ftw = 32'h0123_4567; vecs[4].nticks = 30;
    vecs[5].ftw = 32'hFFFF_FFFF; vecs[5].nticks = 6;
    for (int i = 0; i < 6; i++) begin
      vecs[i].exp_last = ref_sample(32'((longint'(vecs[i].nticks - 1)) * {32'b0, vecs[i].ftw}));
      vecs[i].exp_cs   = int'(((longint'(vecs[i].nticks - 1)) * {32'b0, vecs[i].ftw}) >>> 32);
    end

    rst_n        = 1'b0;
    dds.tick     = 1'b0;
    dds.sync_clr = 1'b0;
    dds.ftw      = 32'h0040_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] reset release and first-sample latency");
    applyStimulus(1'b1, 1'b0, 32'h0040_0000);
    cycles = 0;
    while (cycles < 10) begin
      @(posedge clk);
      #3;
      dds.tick = 1'b0;
      cycles++;
      if (dds.sample_valid) break;
    end
    checkOutput("first_latency", cycles, 3);
    checkOutput("first_sample", int'($signed(dds.sample)), ref_sample(32'd0));
    applyStimulus(1'b0, 1'b0, 32'h0040_0000);
    drain();

    $display("[TB] full cycle with ftw=2^22");
    applyStimulus(1'b0, 1'b1, 32'h0040_0000);
    clear_stats();
    for (int i = 0; i < 1025; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0040_0000);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 32'h0040_0000);
    end
    applyStimulus(1'b0, 1'b0, 32'h0040_0000);
    drain();
    checkOutput("full_cycle_starts", cs_count, 1);
    checkOutput("full_peak_pos", max_s, 2047);
    checkOutput("full_peak_neg", min_s, -2047);

    $display("[TB] back-to-back ticks");
    applyStimulus(1'b0, 1'b1, 32'h0100_0000);
    clear_stats();
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0100_0000);
    applyStimulus(1'b0, 1'b0, 32'h0100_0000);
    drain();
    checkOutput("b2b_run_length", max_run, 8);

    $display("[TB] tuning change and clear with coincident tick");
    applyStimulus(1'b0, 1'b1, 32'h0040_0000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0040_0000);
      applyStimulus(1'b0, 1'b0, 32'h0080_0000);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0080_0000);
      applyStimulus(1'b0, 1'b0, 32'h0080_0000);
    end
    drain();
    applyStimulus(1'b1, 1'b0, 32'h0040_0000);
    applyStimulus(1'b1, 1'b1, 32'h0040_0000);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0040_0000);
    applyStimulus(1'b1, 1'b0, 32'h0040_0000);
    applyStimulus(1'b0, 1'b0, 32'h0040_0000);
    drain();
    checkOutput("after_clear_sample", last_valid_sample, ref_sample(32'd0));

    $display("[TB] reset mid-pipeline");
    applyStimulus(1'b1, 1'b0, 32'h0040_0000);
    applyStimulus(1'b1, 1'b0, 32'h0040_0000);
    @(negedge clk);
    dds.tick = 1'b0;
    rst_n    = 1'b0;
    model_clear();
    model_last = 0;
    #1;
    checkOutput("midrst_sample", int'($signed(dds.sample)), 0);
    checkOutput("midrst_valid", int'(dds.sample_valid), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0040_0000);
    applyStimulus(1'b0, 1'b0, 32'h0040_0000);
    drain();
    checkOutput("post_reset_sample", last_valid_sample, ref_sample(32'd0));

    $display("[TB] negative-frequency wrap");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    clear_stats();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF);
    end
    drain();
    checkOutput("wrap_cycle_starts", cs_count, 18);

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].ftw);
      clear_stats();
      for (int j = 0; j < vecs[i].nticks; j++) applyStimulus(1'b1, 1'b0, vecs[i].ftw);
      applyStimulus(1'b0, 1'b0, vecs[i].ftw);
      drain();
      checkOutput($sformatf("vec%0d_last", i), last_valid_sample, vecs[i].exp_last);
      checkOutput($sformatf("vec%0d_cs", i), cs_count, vecs[i].exp_cs);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      f = $urandom;
      t = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 24) == 0);
      applyStimulus(t, c, f);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
